// File: rtl/mem_miss_arbiter.sv
// Round-robin arbiter sharing one memory port between I$ and D$ misses.
// One request outstanding; responses routed back by cache id.
package mem_miss_pkg;
  localparam int DCACHE_LINE_WIDTH = 128;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  op;
  } memory_request_t;
endpackage

module mem_miss_arbiter
  import mem_miss_pkg::*;
#(
  parameter int RSP_TIMEOUT = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         icache_req_valid,
  input  memory_request_t              icache_req_info,
  input  logic                         dcache_req_valid,
  input  memory_request_t              dcache_req_info,
  output logic                         mem_req_valid,
  output memory_request_t              mem_req_info,
  input  logic                         mem_req_ready,
  input  logic                         mem_rsp_valid,
  input  logic [DCACHE_LINE_WIDTH-1:0] mem_rsp_data,
  output logic                         rsp_valid_miss,
  output logic [DCACHE_LINE_WIDTH-1:0] rsp_data_miss,
  output logic                         rsp_cache_id,
  output logic                         icache_pending,
  output logic                         dcache_pending,
  output logic                         timeout_xcpt
);

  localparam int CW = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(RSP_TIMEOUT - 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(RSP_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      pend_q;
  logic [1:0]      pend_d;
  memory_request_t islot_q;
  memory_request_t dslot_q;
  logic            grant_id_q;
  logic            last_grant_q;
  logic [CW-1:0]   cnt_q;

  logic            grant_en;
  logic            grant_sel;
  logic            rsp_hit;
  logic            tmo_hit;
  logic [1:0]      strobe;
  logic [1:0]      clr;
  logic [1:0]      set;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_en  = 1'b0;
    grant_sel = 1'b0;
    rsp_hit   = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          grant_en  = 1'b1;
          // Bit 1 is D$: a lone D$ request or a tie after an I$ grant.
          grant_sel = (&pend_q) ? ~last_grant_q : pend_q[1];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          rsp_hit = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign strobe = {dcache_req_valid, icache_req_valid};
  assign clr    = {2{rsp_hit | tmo_hit}} & {grant_id_q, ~grant_id_q};
  // A slot freeing this cycle may be refilled in the same cycle.
  assign set    = strobe & (~pend_q | clr);
  assign pend_d = set | (pend_q & ~clr);

  assign mem_req_valid  = (state_q == ISSUE);
  assign icache_pending = pend_q[0];
  assign dcache_pending = pend_q[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q         <= '0;
      islot_q        <= '0;
      dslot_q        <= '0;
      mem_req_info   <= '0;
      grant_id_q     <= 1'b0;
      last_grant_q   <= 1'b0;
      cnt_q          <= '0;
      rsp_valid_miss <= 1'b0;
      rsp_data_miss  <= '0;
      rsp_cache_id   <= 1'b0;
      timeout_xcpt   <= 1'b0;
    end else begin
      pend_q         <= pend_d;
      rsp_valid_miss <= rsp_hit;
      if (set[0]) begin
        islot_q <= icache_req_info;
      end
      if (set[1]) begin
        dslot_q <= dcache_req_info;
      end
      if (grant_en) begin
        mem_req_info <= grant_sel ? dslot_q : islot_q;
        grant_id_q   <= grant_sel;
        last_grant_q <= grant_sel;
      end
      if (state_q == ISSUE && mem_req_ready) begin
        cnt_q <= '0;
      end else if (state_q == WAIT_RSP && cnt_q != TMO_MAX) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (rsp_hit) begin
        rsp_data_miss <= mem_rsp_data;
        rsp_cache_id  <= grant_id_q;
      end
      if (tmo_hit) begin
        timeout_xcpt <= 1'b1;
      end
    end
  end

endmodule
